// File: rtl/mdu_pkg.sv
// Shared definitions for the E-stage multiply/divide unit: opcode values and
// FSM state encoding, imported by e_mdu, mdu_arith and the interface users.
// Opcodes MADD..MSUBU only do something when MDU_MADD_EN is defined.
package mdu_pkg;

  localparam logic [3:0] NOP   = 4'd0;
  localparam logic [3:0] MULT  = 4'd1;
  localparam logic [3:0] MULTU = 4'd2;
  localparam logic [3:0] DIV   = 4'd3;
  localparam logic [3:0] DIVU  = 4'd4;
  localparam logic [3:0] MFHI  = 4'd5;
  localparam logic [3:0] MFLO  = 4'd6;
  localparam logic [3:0] MTHI  = 4'd7;
  localparam logic [3:0] MTLO  = 4'd8;
  localparam logic [3:0] MADD  = 4'd9;
  localparam logic [3:0] MADDU = 4'd10;
  localparam logic [3:0] MSUB  = 4'd11;
  localparam logic [3:0] MSUBU = 4'd12;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } mdu_state_t;

endpackage

// File: rtl/e_mdu_if.sv
// Handshake/bus bundle between the E stage and the multiply/divide unit.
// master: E-stage side (drives start/op/operands, reads busy/HI/LO).
// slave:  e_mdu side. Ports: start, op[3:0], rs_val, rt_val, busy, hi_out, lo_out.
interface e_mdu_if;
  logic        start;
  logic [3:0]  op;
  logic [31:0] rs_val;
  logic [31:0] rt_val;
  logic        busy;
  logic [31:0] hi_out;
  logic [31:0] lo_out;

  modport master (
    output start, op, rs_val, rt_val,
    input  busy, hi_out, lo_out
  );

  modport slave (
    input  start, op, rs_val, rt_val,
    output busy, hi_out, lo_out
  );
endinterface

// File: rtl/mdu_arith.sv
// Combinational multiply/divide datapath: op, rs, rt -> 64-bit {res_hi,res_lo}.
// Latency: none (pure combinational); the caller registers the result.
// Ports: op[3:0], rs, rt in; res_hi, res_lo, div_zero out.
module mdu_arith
  import mdu_pkg::*;
(
  input  logic [3:0]  op,
  input  logic [31:0] rs,
  input  logic [31:0] rt,
  output logic [31:0] res_hi,
  output logic [31:0] res_lo,
  output logic        div_zero
);

  logic [63:0] rs_sx, rt_sx;
  logic [63:0] prod_s, prod_u;
  logic [31:0] rt_safe;
  logic        ovf;
  logic [31:0] q_s, r_s, q_u, r_u;

  // Sign-extend to 64 bits first so the truncated 64x64 product is the exact
  // signed 32x32 product.
  assign rs_sx  = {{32{rs[31]}}, rs};
  assign rt_sx  = {{32{rt[31]}}, rt};
  assign prod_s = rs_sx * rt_sx;
  assign prod_u = {32'h0, rs} * {32'h0, rt};

  assign div_zero = (rt == 32'h0);
  // Substitute a non-zero divisor so the divider never sees zero; the result
  // is discarded by the caller in that case anyway.
  assign rt_safe  = div_zero ? 32'h1 : rt;
  // Most-negative / -1 overflows the signed quotient; pin the result explicitly.
  assign ovf      = (rs == 32'h8000_0000) && (rt == 32'hFFFF_FFFF);

  assign q_s = ovf ? 32'h8000_0000 : 32'($signed(rs) / $signed(rt_safe));
  assign r_s = ovf ? 32'h0         : 32'($signed(rs) % $signed(rt_safe));
  assign q_u = rs / rt_safe;
  assign r_u = rs % rt_safe;

  always_comb begin
    res_hi = 32'h0;
    res_lo = 32'h0;
    case (op)
      MULT, MADD, MSUB:    {res_hi, res_lo} = prod_s;
      MULTU, MADDU, MSUBU: {res_hi, res_lo} = prod_u;
      DIV:                 begin res_hi = r_s; res_lo = q_s; end
      DIVU:                begin res_hi = r_u; res_lo = q_u; end
      default:             ;
    endcase
  end

endmodule

// File: rtl/e_mdu.sv
// Execute-stage multiply/divide unit holding architectural HI/LO.
// Latency: MULT* busy MULT_CYCLES, DIV* busy DIV_CYCLES; MTHI/MTLO update next edge.
// Backpressure: busy stalls D; start while busy is ignored. Optional: MDU_MADD_EN.
// Ports: clk, reset (sync, active-high), bus (e_mdu_if.slave).
module e_mdu
  import mdu_pkg::*;
#(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input logic    clk,
  input logic    reset,
  e_mdu_if.slave bus
);

  mdu_state_t  state;
  logic [15:0] cnt;
  logic        busy_q;
  logic [31:0] hi_q, lo_q;
  logic [31:0] pend_hi, pend_lo;
  logic        pend_wr;     // clear on divide-by-zero: window runs, no commit
  logic [31:0] res_hi, res_lo;
  logic        div_zero;

  mdu_arith u_arith (
    .op       (bus.op),
    .rs       (bus.rs_val),
    .rt       (bus.rt_val),
    .res_hi   (res_hi),
    .res_lo   (res_lo),
    .div_zero (div_zero)
  );

`ifdef MDU_MADD_EN
  logic        pend_acc;
  logic        pend_sub;
  logic [63:0] acc_sum;
  // Accumulates onto HI/LO as they are at commit time, not at issue time.
  assign acc_sum = pend_sub ? ({hi_q, lo_q} - {pend_hi, pend_lo})
                            : ({hi_q, lo_q} + {pend_hi, pend_lo});
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= ST_IDLE;
      cnt     <= 16'h0;
      busy_q  <= 1'b0;
      hi_q    <= 32'h0;
      lo_q    <= 32'h0;
      pend_hi <= 32'h0;
      pend_lo <= 32'h0;
      pend_wr <= 1'b0;
`ifdef MDU_MADD_EN
      pend_acc <= 1'b0;
      pend_sub <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (bus.start) begin
            case (bus.op)
              MULT, MULTU: begin
                pend_hi <= res_hi;
                pend_lo <= res_lo;
                pend_wr <= 1'b1;
                cnt     <= 16'(MULT_CYCLES - 1);
                state   <= ST_BUSY;
                busy_q  <= 1'b1;
`ifdef MDU_MADD_EN
                pend_acc <= 1'b0;
`endif
              end
              DIV, DIVU: begin
                pend_hi <= res_hi;
                pend_lo <= res_lo;
                pend_wr <= !div_zero;
                cnt     <= 16'(DIV_CYCLES - 1);
                state   <= ST_BUSY;
                busy_q  <= 1'b1;
`ifdef MDU_MADD_EN
                pend_acc <= 1'b0;
`endif
              end
              MTHI: hi_q <= bus.rs_val;
              MTLO: lo_q <= bus.rs_val;
`ifdef MDU_MADD_EN
              MADD, MADDU, MSUB, MSUBU: begin
                pend_hi  <= res_hi;
                pend_lo  <= res_lo;
                pend_wr  <= 1'b1;
                pend_acc <= 1'b1;
                pend_sub <= (bus.op == MSUB) || (bus.op == MSUBU);
                cnt      <= 16'(MULT_CYCLES - 1);
                state    <= ST_BUSY;
                busy_q   <= 1'b1;
              end
`endif
              default: ;  // NOP, MFHI, MFLO, unknown codes
            endcase
          end
        end
        ST_BUSY: begin
          if (cnt == 16'h0) begin
            if (pend_wr) begin
`ifdef MDU_MADD_EN
              if (pend_acc) begin
                {hi_q, lo_q} <= acc_sum;
              end else begin
                hi_q <= pend_hi;
                lo_q <= pend_lo;
              end
`else
              hi_q <= pend_hi;
              lo_q <= pend_lo;
`endif
            end
            state  <= ST_IDLE;
            busy_q <= 1'b0;
          end else begin
            cnt <= cnt - 16'h1;
          end
        end
        default: begin
          state  <= ST_IDLE;
          busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy   = busy_q;
  assign bus.hi_out = hi_q;
  assign bus.lo_out = lo_q;

endmodule

// File: tb/tb_e_mdu.sv
// Self-checking bench for e_mdu: directed scenarios followed by random ops,
// compared against a 64-bit arithmetic reference of HI/LO and busy duration.
module tb_e_mdu;
  import mdu_pkg::*;

  localparam int MC = 5;
  localparam int DC = 10;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  e_mdu_if bus ();

  e_mdu #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;
  logic [31:0] hi_m, lo_m;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: what HI/LO become and how long busy lasts.
  task automatic model(input logic [3:0] op, input logic [31:0] rs, input logic [31:0] rt,
                       output int cyc);
    longint a, b, q, r;
    logic [63:0] p, acc;
    cyc = 0;
    case (op)
      MULT:  begin cyc = MC; p = 64'(longint'($signed(rs)) * longint'($signed(rt))); {hi_m, lo_m} = p; end
      MULTU: begin cyc = MC; p = {32'h0, rs} * {32'h0, rt}; {hi_m, lo_m} = p; end
      DIV: begin
        cyc = DC;
        if (rt != 32'h0) begin
          a = longint'($signed(rs)); b = longint'($signed(rt));
          q = a / b; r = a % b;
          lo_m = q[31:0]; hi_m = r[31:0];
        end
      end
      DIVU: begin
        cyc = DC;
        if (rt != 32'h0) begin
          a = longint'({32'h0, rs}); b = longint'({32'h0, rt});
          q = a / b; r = a % b;
          lo_m = q[31:0]; hi_m = r[31:0];
        end
      end
      MTHI: hi_m = rs;
      MTLO: lo_m = rs;
`ifdef MDU_MADD_EN
      MADD, MSUB, MADDU, MSUBU: begin
        cyc = MC;
        if (op == MADD || op == MSUB) p = 64'(longint'($signed(rs)) * longint'($signed(rt)));
        else                          p = {32'h0, rs} * {32'h0, rt};
        acc = {hi_m, lo_m};
        if (op == MSUB || op == MSUBU) acc = acc - p;
        else                           acc = acc + p;
        {hi_m, lo_m} = acc;
      end
`endif
      default: ;
    endcase
  endtask

  task automatic do_op(input string tag, input logic [3:0] op,
                       input logic [31:0] rs, input logic [31:0] rt);
    int exp_cyc, n;
    model(op, rs, rt, exp_cyc);
    @(negedge clk);
    bus.start = 1'b1; bus.op = op; bus.rs_val = rs; bus.rt_val = rt;
    @(negedge clk);
    bus.start = 1'b0; bus.op = NOP;
    n = 0;
    while (bus.busy === 1'b1 && n < 200) begin
      n++;
      @(negedge clk);
    end
    chk({tag, " busy_cycles"}, 32'(n), 32'(exp_cyc));
    chk({tag, " hi"}, bus.hi_out, hi_m);
    chk({tag, " lo"}, bus.lo_out, lo_m);
  endtask

  initial begin
    int n, cyc;
    logic [3:0] rop;
    logic [31:0] rrs, rrt;
    logic [3:0] ops [12];
    ops = '{MULT, MULTU, DIV, DIVU, MTHI, MTLO, MFHI, MFLO, NOP, MADD, MSUBU, 4'd15};

    bus.start = 1'b0; bus.op = NOP; bus.rs_val = 32'h0; bus.rt_val = 32'h0;
    reset = 1'b1;
    hi_m = 32'h0; lo_m = 32'h0;
    repeat (3) @(negedge clk);
    chk("reset busy", {31'h0, bus.busy}, 32'h0);
    chk("reset hi", bus.hi_out, 32'h0);
    chk("reset lo", bus.lo_out, 32'h0);
    reset = 1'b0;

    // 1: multiply
    do_op("mult_neg1x2", MULT, 32'hFFFF_FFFF, 32'h2);
    chk("mult const hi", bus.hi_out, 32'hFFFF_FFFF);
    chk("mult const lo", bus.lo_out, 32'hFFFF_FFFE);
    do_op("multu_ffx2", MULTU, 32'hFFFF_FFFF, 32'h2);
    chk("multu const hi", bus.hi_out, 32'h1);
    chk("multu const lo", bus.lo_out, 32'hFFFF_FFFE);

    // 2: divide
    do_op("div_m7_2", DIV, 32'hFFFF_FFF9, 32'h2);
    chk("div const lo", bus.lo_out, 32'hFFFF_FFFD);
    chk("div const hi", bus.hi_out, 32'hFFFF_FFFF);
    do_op("divu_7_2", DIVU, 32'h7, 32'h2);
    chk("divu const lo", bus.lo_out, 32'h3);
    chk("divu const hi", bus.hi_out, 32'h1);
    do_op("div_ovf", DIV, 32'h8000_0000, 32'hFFFF_FFFF);
    chk("div_ovf const lo", bus.lo_out, 32'h8000_0000);
    chk("div_ovf const hi", bus.hi_out, 32'h0);

    // 3: divide by zero keeps HI/LO
    do_op("mtlo_0", MTLO, 32'h0, 32'h0);
    do_op("mthi_1234", MTHI, 32'h1234, 32'h0);
    do_op("div_by_0", DIV, 32'd9, 32'h0);
    chk("div0 const hi", bus.hi_out, 32'h1234);
    chk("div0 const lo", bus.lo_out, 32'h0);

    // 4: starts while busy are ignored
    @(negedge clk);
    bus.start = 1'b1; bus.op = MULT; bus.rs_val = 32'd3; bus.rt_val = 32'd4;
    @(negedge clk);
    bus.start = 1'b0;
    chk("ign busy c1", {31'h0, bus.busy}, 32'h1);
    @(negedge clk);
    chk("ign busy c2", {31'h0, bus.busy}, 32'h1);
    bus.start = 1'b1; bus.op = MTLO; bus.rs_val = 32'h55;
    @(negedge clk);
    bus.op = DIV; bus.rs_val = 32'd100; bus.rt_val = 32'd3;
    @(negedge clk);
    bus.start = 1'b0; bus.op = NOP;
    n = 3;
    while (bus.busy === 1'b1 && n < 200) begin
      n++;
      @(negedge clk);
    end
    model(MULT, 32'd3, 32'd4, cyc);
    chk("ign busy_cycles", 32'(n), 32'(MC));
    chk("ign lo", bus.lo_out, 32'd12);
    chk("ign hi", bus.hi_out, 32'h0);

    // 5: reset mid-operation aborts the pending result
    @(negedge clk);
    bus.start = 1'b1; bus.op = MULT; bus.rs_val = 32'd6; bus.rt_val = 32'd7;
    @(negedge clk);
    bus.start = 1'b0; bus.op = NOP;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    hi_m = 32'h0; lo_m = 32'h0;
    chk("rst_mid busy", {31'h0, bus.busy}, 32'h0);
    chk("rst_mid hi", bus.hi_out, 32'h0);
    chk("rst_mid lo", bus.lo_out, 32'h0);
    reset = 1'b0;
    repeat (10) @(negedge clk);
    chk("rst_late busy", {31'h0, bus.busy}, 32'h0);
    chk("rst_late hi", bus.hi_out, 32'h0);
    chk("rst_late lo", bus.lo_out, 32'h0);

    // 6: multiply-accumulate (NOP without the feature)
    do_op("madd_pre_hi", MTHI, 32'h0, 32'h0);
    do_op("madd_pre_lo", MTLO, 32'd10, 32'h0);
    do_op("madd_2x3", MADD, 32'd2, 32'd3);
`ifdef MDU_MADD_EN
    chk("madd const lo", bus.lo_out, 32'd16);
    do_op("msubu_1x17", MSUBU, 32'd1, 32'd17);
    chk("msubu const hi", bus.hi_out, 32'hFFFF_FFFF);
    chk("msubu const lo", bus.lo_out, 32'hFFFF_FFFF);
`else
    chk("madd_nop const lo", bus.lo_out, 32'd10);
    chk("madd_nop const hi", bus.hi_out, 32'h0);
`endif

    // Random operations against the reference
    for (int i = 0; i < 40; i++) begin
      rop = ops[$urandom_range(0, 11)];
      rrs = $urandom;
      if ($urandom_range(0, 3) == 0) rrs = 32'(int'($urandom_range(0, 40)) - 20);
      rrt = $urandom;
      case ($urandom_range(0, 5))
        0: rrt = 32'h0;
        1: rrt = 32'(int'($urandom_range(0, 16)) - 8);
        default: ;
      endcase
      do_op($sformatf("rand%0d_op%0d", i, rop), rop, rrs, rrt);
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
